traffic_sensor_ctrl: RTL and testbench

TRAFFIC_SENSOR_CTRL -- requirements
Module: traffic_sensor_ctrl

---
 rtl/traffic_pkg.sv | 23 ++
 rtl/sensor_debounce.sv | 44 ++++
 rtl/traffic_sensor_ctrl.sv | 89 ++++++++
 tb/tb_traffic_sensor_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared encodings for the traffic signal interface and the sensor request FSM.
package traffic_pkg;

  typedef enum logic [1:0] {
    LIGHT_RED     = 2'b00,
    LIGHT_GREEN   = 2'b01,
    LIGHT_YELLOW  = 2'b10,
    LIGHT_ILLEGAL = 2'b11
  } light_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_REQUEST = 2'b01,
    ST_SERVED  = 2'b10,
    ST_FAULT   = 2'b11
  } state_t;

  // States in which the signal controller is being asked for service.
  function automatic logic sensor_active(input state_t s);
    return (s == ST_REQUEST) || (s == ST_FAULT);
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Loop detector front end: 2-flop synchronizer, level debouncer and a
// registered single-cycle pulse on each accepted 0->1 level change.
module sensor_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic loop_raw,
  output logic arrival
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             loop_db;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      loop_db <= 1'b0;
      cnt     <= '0;
      arrival <= 1'b0;
    end else begin
      sync1   <= loop_raw;
      sync2   <= sync1;
      arrival <= 1'b0;
      if (sync2 == loop_db) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        // This edge is the DEBOUNCE_CYCLES-th consecutive differing cycle.
        cnt     <= '0;
        loop_db <= sync2;
        arrival <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/traffic_sensor_ctrl.sv
// Vehicle-loop service requester: debounced arrivals drive a request FSM
// with wait timeout, pending-service flag and a saturating arrival counter.
module traffic_sensor_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned MAX_WAIT        = 64,
  parameter int unsigned COUNT_W         = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               loop_raw,
  input  logic [1:0]         light,
  output logic               sensor,
  output logic [COUNT_W-1:0] car_count,
  output logic               fault
);

  localparam int unsigned WAIT_W = $clog2(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  logic              arrival;
  state_t            state;
  state_t            state_nxt;
  logic              pending;
  logic              pending_nxt;
  logic [WAIT_W-1:0] wait_cnt;

  sensor_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk     (clk),
    .rst     (rst),
    .loop_raw(loop_raw),
    .arrival (arrival)
  );

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    case (state)
      ST_IDLE: begin
        if (arrival) state_nxt = ST_REQUEST;
      end
      ST_REQUEST: begin
        if (light == LIGHT_GREEN)      state_nxt = ST_SERVED;
        else if (wait_cnt == WAIT_LAST) state_nxt = ST_FAULT;
      end
      ST_SERVED: begin
        if (arrival) pending_nxt = 1'b1;
        if (light != LIGHT_GREEN)
          state_nxt = (pending || arrival) ? ST_REQUEST : ST_IDLE;
      end
      ST_FAULT: begin
        if (light == LIGHT_GREEN) state_nxt = ST_SERVED;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (light == LIGHT_ILLEGAL) state_nxt = ST_FAULT;
    // Pending only survives while SERVED is held.
    if (state_nxt != ST_SERVED) pending_nxt = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      pending  <= 1'b0;
      wait_cnt <= '0;
      sensor   <= 1'b0;
      fault    <= 1'b0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
      sensor  <= sensor_active(state_nxt);
      fault   <= (state_nxt == ST_FAULT);
      if (state_nxt == ST_REQUEST)
        wait_cnt <= (state == ST_REQUEST) ? wait_cnt + 1'b1 : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      car_count <= '0;
    end else if (arrival && (car_count != '1)) begin
      car_count <= car_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_traffic_sensor_ctrl.sv
// Scoreboard bench for traffic_sensor_ctrl: expectations are queued with the
// clock edge they apply to and checked on the following falling edge.
module tb_traffic_sensor_ctrl;
  import traffic_pkg::*;

  localparam int S_SENSOR = 0;
  localparam int S_FAULT  = 1;
  localparam int S_CNT8   = 2;
  localparam int S_CNT2   = 3;

  typedef struct {
    string tag;
    int    at;
    int    sel;
    int    val;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       loop_raw;
  logic [1:0] light;
  logic       sensor_a, fault_a;
  logic [7:0] count8;
  logic       sensor_b, fault_b;
  logic [1:0] count2;

  int   checks = 0;
  int   errors = 0;
  int   edge_n = 0;
  exp_t sb[$];

  traffic_sensor_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .loop_raw (loop_raw),
    .light    (light),
    .sensor   (sensor_a),
    .car_count(count8),
    .fault    (fault_a)
  );

  traffic_sensor_ctrl #(
    .COUNT_W(2)
  ) dut_c2 (
    .clk      (clk),
    .rst      (rst),
    .loop_raw (loop_raw),
    .light    (light),
    .sensor   (sensor_b),
    .car_count(count2),
    .fault    (fault_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic check_eq(input string tag, input int obs, input int exp_v);
    checks++;
    if (obs != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp_v, edge_n);
    end
  endtask

  function automatic int observe(input int sel);
    case (sel)
      S_SENSOR: return int'(sensor_a);
      S_FAULT:  return int'(fault_a);
      S_CNT8:   return int'(count8);
      default:  return int'(count2);
    endcase
  endfunction

  task automatic expect_at(input string tag, input int at, input int sel, input int val);
    sb.push_back('{tag, at, sel, val});
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at == edge_n) begin
        check_eq(sb[i].tag, observe(sb[i].sel), sb[i].val);
        sb.delete(i);
      end else if (sb[i].at < edge_n) begin
        check_eq({sb[i].tag, "_late"}, edge_n, sb[i].at);
        sb.delete(i);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic apply_reset();
    rst      = 1'b1;
    loop_raw = 1'b0;
    light    = LIGHT_RED;
    #1;
    check_eq("rst_sensor", int'(sensor_a), 0);
    check_eq("rst_fault",  int'(fault_a),  0);
    check_eq("rst_count",  int'(count8),   0);
    check_eq("rst_count2", int'(count2),   0);
    step(2);
    rst = 1'b0;
    step(1);
  endtask

  initial begin
    int e;
    rst      = 1'b0;
    loop_raw = 1'b0;
    light    = LIGHT_RED;
    #1;

    // Basic latency, GREEN service, YELLOW with nothing pending -> IDLE
    apply_reset();
    e = edge_n;
    loop_raw = 1'b1;
    expect_at("a_sensor_pre",  e + 6, S_SENSOR, 0);
    expect_at("a_count_pre",   e + 6, S_CNT8,   0);
    expect_at("a_sensor_rise", e + 7, S_SENSOR, 1);
    expect_at("a_count",       e + 7, S_CNT8,   1);
    expect_at("a_count2",      e + 7, S_CNT2,   1);
    step(8);
    light = LIGHT_GREEN;
    expect_at("a_served_sensor", e + 9, S_SENSOR, 0);
    expect_at("a_served_fault",  e + 9, S_FAULT,  0);
    step(3);
    light = LIGHT_YELLOW;
    expect_at("a_idle_sensor",  e + 12, S_SENSOR, 0);
    expect_at("a_idle_sensor2", e + 14, S_SENSOR, 0);
    step(4);
    loop_raw = 1'b0;
    step(10);

    // 3-cycle glitches rejected; a 4-cycle pulse is just long enough
    apply_reset();
    e = edge_n;
    for (int k = 1; k <= 24; k++) begin
      expect_at("b_glitch_sensor", e + k, S_SENSOR, 0);
      expect_at("b_glitch_count",  e + k, S_CNT8,   0);
    end
    for (int p = 0; p < 3; p++) begin
      loop_raw = 1'b1;
      step(3);
      loop_raw = 1'b0;
      step(5);
    end
    e = edge_n;
    loop_raw = 1'b1;
    expect_at("b_pulse4_pre",   e + 6, S_SENSOR, 0);
    expect_at("b_pulse4_rise",  e + 7, S_SENSOR, 1);
    expect_at("b_pulse4_count", e + 7, S_CNT8,   1);
    step(4);
    loop_raw = 1'b0;
    step(10);

    // Timeout to FAULT exactly MAX_WAIT cycles after the request
    apply_reset();
    e = edge_n;
    loop_raw = 1'b1;
    expect_at("c_sensor_rise",   e + 7,  S_SENSOR, 1);
    expect_at("c_fault_before",  e + 70, S_FAULT,  0);
    expect_at("c_fault_rise",    e + 71, S_FAULT,  1);
    expect_at("c_fault_sensor",  e + 71, S_SENSOR, 1);
    step(72);
    light = LIGHT_GREEN;
    expect_at("c_clear_fault",  e + 73, S_FAULT,  0);
    expect_at("c_clear_sensor", e + 73, S_SENSOR, 0);
    step(2);
    light = LIGHT_RED;
    expect_at("c_idle_sensor", e + 76, S_SENSOR, 0);
    step(4);

    // Pending arrival in SERVED, then arrival coinciding with GREEN in REQUEST
    apply_reset();
    e = edge_n;
    loop_raw = 1'b1;
    expect_at("d_sensor_rise", e + 7, S_SENSOR, 1);
    step(8);
    light = LIGHT_GREEN;
    expect_at("d_served", e + 9, S_SENSOR, 0);
    step(1);
    loop_raw = 1'b0;
    step(7);
    loop_raw = 1'b1;
    expect_at("d_count2nd",      e + 23, S_CNT8,   2);
    expect_at("d_served_hold",   e + 23, S_SENSOR, 0);
    step(8);
    light = LIGHT_YELLOW;
    expect_at("d_pending_req",   e + 25, S_SENSOR, 1);
    step(1);
    loop_raw = 1'b0;
    step(7);
    loop_raw = 1'b1;
    step(6);
    light = LIGHT_GREEN;
    expect_at("d_sim_served", e + 39, S_SENSOR, 0);
    expect_at("d_sim_count",  e + 39, S_CNT8,   3);
    step(2);
    light = LIGHT_YELLOW;
    expect_at("d_no_pending",  e + 41, S_SENSOR, 0);
    expect_at("d_no_pending2", e + 43, S_SENSOR, 0);
    step(5);

    // Saturation of a 2-bit counter; illegal light forces FAULT
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      e = edge_n;
      loop_raw = 1'b1;
      expect_at("e_count2", e + 7, S_CNT2, (k + 1 > 3) ? 3 : k + 1);
      expect_at("e_count8", e + 7, S_CNT8, k + 1);
      step(8);
      loop_raw = 1'b0;
      step(8);
    end
    apply_reset();
    e = edge_n;
    light = LIGHT_ILLEGAL;
    expect_at("e_illegal_pre",    e,     S_FAULT,  0);
    expect_at("e_illegal_fault",  e + 1, S_FAULT,  1);
    expect_at("e_illegal_sensor", e + 1, S_SENSOR, 1);
    step(2);
    light = LIGHT_GREEN;
    expect_at("e_recover_fault", e + 3, S_FAULT, 0);
    step(3);

    // Asynchronous reset mid-REQUEST, then a full fresh timeout
    apply_reset();
    e = edge_n;
    loop_raw = 1'b1;
    expect_at("f_sensor_rise", e + 7,  S_SENSOR, 1);
    expect_at("f_pre_reset",   e + 36, S_SENSOR, 1);
    expect_at("f_pre_count",   e + 36, S_CNT8,   1);
    step(37);
    apply_reset();
    e = edge_n;
    loop_raw = 1'b1;
    expect_at("f_new_rise",     e + 7,  S_SENSOR, 1);
    expect_at("f_new_count",    e + 7,  S_CNT8,   1);
    expect_at("f_new_no_fault", e + 70, S_FAULT,  0);
    expect_at("f_new_fault",    e + 71, S_FAULT,  1);
    step(73);

    for (int i = 0; i < 200 && sb.size() > 0; i++) step(1);
    check_eq("sb_drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
